conv_frame_sequencer: RTL and testbench

Avalon-MM-controlled sequencer for the 3x3 convolution datapath in the Nios II system. Software programs frame dimensions and writes a start bit. The block then raster-scans the incoming pixel stream, tells the datapath when the line buffers shift and when a full 3x3 window is valid, and counts datapath results. It reports completion through a sticky status bit and an optional interrupt.

---
 rtl/conv_seq_pkg.sv | 32 +++
 rtl/conv_seq_raster_cnt.sv | 44 ++++
 rtl/conv_frame_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared definitions for the 3x3 convolution frame sequencer: FSM state
// encoding, Avalon register map, control/status bit positions and the
// DIM register field offsets.
package conv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Register addresses (word offsets on the Avalon slave)
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIM    = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    // CTRL bits
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    // STATUS bits
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_DIM_ERR = 2;

    // DIM field offsets
    localparam int DIM_WIDTH_LSB  = 0;
    localparam int DIM_HEIGHT_LSB = 16;

endpackage

// File: rtl/conv_seq_raster_cnt.sv
// Raster-scan position tracker: column/row counters that advance on each
// accepted pixel, plus the last-pixel flag and the 3x3-window-complete compare.
module conv_seq_raster_cnt #(
    parameter int DIM_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             last_pix,
    output logic             win_ok
);

    logic col_at_end;

    assign col_at_end = (col == width - DIM_W'(1));

    // Column counts up per accepted pixel and wraps at width-1, bumping the row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_at_end) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end

    // A window is complete once two full rows and two columns precede the pixel
    assign last_pix = col_at_end && (row == height - DIM_W'(1));
    assign win_ok   = (row >= DIM_W'(2)) && (col >= DIM_W'(2));

endmodule

// File: rtl/conv_frame_sequencer.sv
// Avalon-MM controlled sequencer for the 3x3 convolution datapath. Software
// programs DIM and writes START; the block raster-scans the pixel stream,
// flags line-buffer shifts and complete windows, counts datapath results and
// reports completion through a sticky DONE bit and a level interrupt.
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int DIM_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        line_shift,
    output logic        win_valid,
    output logic        frame_start,
    input  logic        dp_out_valid,
    output logic        busy,
    output state_e      state_dbg
);

    localparam int CW = 2 * DIM_W;

    state_e           state;
    logic             irq_en;
    logic             done;
    logic             dim_err;
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;
    logic [CW-1:0]    result_cnt;
    logic [CW-1:0]    expected;
    logic [CW-1:0]    frame_windows;

    logic wr_en, wr_ctrl, wr_status, wr_dim;
    logic start_req, abort_req, dims_ok, launch;
    logic accept, res_inc, cnt_done;
    logic [DIM_W-1:0] col, row;
    logic last_pix, win_ok;
    logic unused_wdata;

    assign wr_en     = chipselect & ~write_n;
    assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
    assign wr_status = wr_en && (address == ADDR_STATUS);
    assign wr_dim    = wr_en && (address == ADDR_DIM);
    assign start_req = wr_ctrl & writedata[CTRL_START];
    assign abort_req = wr_ctrl & writedata[CTRL_ABORT];
    assign dims_ok   = (width >= DIM_W'(3)) && (height >= DIM_W'(3));
    assign launch    = (state == ST_IDLE) && start_req && dims_ok;

    // Stream handshake: a pixel transfers in any cycle where pix_valid and
    // pix_ready are both high. pix_ready is a registered function of state and
    // never depends on pix_valid; the source may hold pix_valid as it likes.
    assign accept     = pix_valid & pix_ready;
    assign line_shift = accept;
    assign win_valid  = accept & win_ok;

    // Results saturate at the expected count; the final one ends the frame
    assign res_inc  = dp_out_valid && (state != ST_IDLE) && (result_cnt != expected);
    assign cnt_done = (result_cnt == expected) ||
                      (res_inc && (result_cnt + CW'(1) == expected));

    assign frame_windows = CW'(width - DIM_W'(2)) * CW'(height - DIM_W'(2));

    assign busy      = (state != ST_IDLE);
    assign irq       = done & irq_en;
    assign state_dbg = state;
    assign unused_wdata = ^writedata;

    conv_seq_raster_cnt #(.DIM_W(DIM_W)) u_raster (
        .clk      (clk),
        .reset    (reset),
        .clear    (launch),
        .advance  (accept),
        .width    (width),
        .height   (height),
        .col      (col),
        .row      (row),
        .last_pix (last_pix),
        .win_ok   (win_ok)
    );

    // Software-owned configuration: IRQ enable and frame dimensions (frozen while busy)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            width  <= '0;
            height <= '0;
        end else begin
            if (wr_ctrl) begin
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (wr_dim && (state == ST_IDLE)) begin
                width  <= writedata[DIM_WIDTH_LSB +: DIM_W];
                height <= writedata[DIM_HEIGHT_LSB +: DIM_W];
            end
        end
    end

    // Frame FSM with registered handshake/pulse outputs, sticky flags and result counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pix_ready   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            dim_err     <= 1'b0;
            result_cnt  <= '0;
            expected    <= '0;
        end else begin
            frame_start <= 1'b0;
            // Write-1-clear first so a same-cycle set below takes priority
            if (wr_status && writedata[STAT_DONE]) begin
                done <= 1'b0;
            end
            if (wr_status && writedata[STAT_DIM_ERR]) begin
                dim_err <= 1'b0;
            end
            if (res_inc) begin
                result_cnt <= result_cnt + CW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        if (dims_ok) begin
                            state       <= ST_RUN;
                            pix_ready   <= 1'b1;
                            frame_start <= 1'b1;
                            result_cnt  <= '0;
                            expected    <= frame_windows;
                        end else begin
                            dim_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort_req) begin
                        state     <= ST_IDLE;
                        pix_ready <= 1'b0;
                    end else if (accept && last_pix) begin
                        pix_ready <= 1'b0;
                        if (cnt_done) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort_req) begin
                        state <= ST_IDLE;
                    end else if (cnt_done) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pix_ready <= 1'b0;
                end
            endcase
        end
    end

    // Zero-wait-state register readback; unmapped bits read as zero
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_STATUS: begin
                readdata[STAT_BUSY]    = busy;
                readdata[STAT_DONE]    = done;
                readdata[STAT_DIM_ERR] = dim_err;
            end
            ADDR_DIM: begin
                readdata[DIM_WIDTH_LSB +: DIM_W]  = width;
                readdata[DIM_HEIGHT_LSB +: DIM_W] = height;
            end
            default: begin
                readdata[CW-1:0] = result_cnt;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer: register-map vector table,
// full frames against a raster model with a 3-cycle datapath stand-in, and
// hand-written sequences for DIM_ERR, ABORT, busy-time writes and reset.
module tb_conv_frame_sequencer;
    import conv_seq_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        pix_valid;
    logic        pix_ready;
    logic        line_shift;
    logic        win_valid;
    logic        frame_start;
    logic        dp_out_valid;
    logic        busy;
    state_e      state_dbg;

    conv_frame_sequencer #(.DIM_W(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .irq          (irq),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .line_shift   (line_shift),
        .win_valid    (win_valid),
        .frame_start  (frame_start),
        .dp_out_valid (dp_out_valid),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;
    logic [31:0] exp_q[$];   // expected win_valid for each accepted pixel
    int sched[$];            // cycles in which the datapath returns a result

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } reg_vec_t;

    reg_vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Drives a started frame until busy drops, checking handshake and windows
    task automatic run_frame(input int w, input int h, input bit toggle, input bit expect_fs,
                             input int budget, output int n_acc, output int n_win,
                             output int n_res, output int gap);
        int col, row, total, last_res;
        bit exp_ready, exp_acc;
        logic [31:0] e;
        col = 0; row = 0; total = w * h; last_res = -1;
        n_acc = 0; n_win = 0; n_res = 0; gap = -1;
        for (int i = 0; i < budget; i++) begin
            pix_valid    = toggle ? ((i % 2) == 0) : 1'b1;
            dp_out_valid = (sched.size() > 0 && sched[0] == cyc);
            if (dp_out_valid) void'(sched.pop_front());
            @(negedge clk);
            if (expect_fs && i < 2) chk("frame_start pulse", 32'(frame_start), 32'(i == 0));
            exp_ready = (n_acc < total);
            exp_acc   = pix_valid && exp_ready;
            chk("pix_ready", 32'(pix_ready), 32'(exp_ready));
            chk("line_shift", 32'(line_shift), 32'(exp_acc));
            if (exp_acc) begin
                exp_q.push_back(32'(row >= 2 && col >= 2));
                n_acc++;
                if (col == w - 1) begin
                    col = 0;
                    row++;
                end else begin
                    col++;
                end
            end
            if (line_shift) begin
                if (exp_q.size() == 0) chk("win_valid with no expected accept", 32'(1), 32'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("win_valid", 32'(win_valid), e);
                end
            end else if (win_valid) begin
                chk("win_valid without line_shift", 32'(win_valid), 32'(0));
            end
            if (win_valid) begin
                n_win++;
                sched.push_back(cyc + 3);
            end
            if (dp_out_valid) begin
                n_res++;
                last_res = cyc;
            end
            if (!busy) begin
                gap = cyc - last_res;
                tick();
                break;
            end
            tick();
        end
        pix_valid    = 1'b0;
        dp_out_valid = 1'b0;
        chk("frame completed within budget", 32'(gap >= 0), 32'(1));
    endtask

    initial begin
        logic [31:0] rd;
        int n_acc, n_win, n_res, gap, cnt;

        // Clock/reset
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        pix_valid = 1'b0; dp_out_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset pix_ready", 32'(pix_ready), 0);
        chk("reset irq", 32'(irq), 0);
        chk("reset frame_start", 32'(frame_start), 0);
        chk("reset line_shift", 32'(line_shift), 0);
        chk("reset win_valid", 32'(win_valid), 0);
        chk("reset state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Register map vectors
        vecs[0] = '{ADDR_CTRL,   1'b0, 32'h0,         32'h0};
        vecs[1] = '{ADDR_STATUS, 1'b0, 32'h0,         32'h0};
        vecs[2] = '{ADDR_DIM,    1'b0, 32'h0,         32'h0};
        vecs[3] = '{ADDR_RESULT, 1'b0, 32'h0,         32'h0};
        vecs[4] = '{ADDR_DIM,    1'b1, 32'hFFFF_FFFF, 32'h03FF_03FF};
        vecs[5] = '{ADDR_CTRL,   1'b1, 32'h0000_0002, 32'h0000_0002};
        vecs[6] = '{ADDR_CTRL,   1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{ADDR_STATUS, 1'b1, 32'h0000_0006, 32'h0000_0000};
        vecs[8] = '{ADDR_RESULT, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9] = '{ADDR_DIM,    1'b1, 32'h0004_0005, 32'h0004_0005};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].wdata);
            reg_read(vecs[i].addr, rd);
            chk($sformatf("regvec[%0d]", i), rd, vecs[i].exp_rd);
        end

        // 5x4 frame, pixels every cycle
        reg_write(ADDR_CTRL, 32'h1);
        chk("busy after START", 32'(busy), 1);
        run_frame(5, 4, 1'b0, 1'b1, 200, n_acc, n_win, n_res, gap);
        chk("f1 accepts", n_acc, 20);
        chk("f1 windows", n_win, 6);
        chk("f1 results", n_res, 6);
        chk("f1 busy drop gap", gap, 1);
        reg_read(ADDR_RESULT, rd);
        chk("f1 RESULT_CNT", rd, 6);
        reg_read(ADDR_STATUS, rd);
        chk("f1 STATUS", rd, 32'h2);
        chk("f1 irq disabled", 32'(irq), 0);

        // Same frame, toggling pix_valid, IRQ enabled
        reg_write(ADDR_STATUS, 32'h2);
        reg_read(ADDR_STATUS, rd);
        chk("DONE cleared", rd, 32'h0);
        reg_write(ADDR_CTRL, 32'h3);
        run_frame(5, 4, 1'b1, 1'b1, 200, n_acc, n_win, n_res, gap);
        chk("f2 accepts", n_acc, 20);
        chk("f2 windows", n_win, 6);
        chk("f2 results", n_res, 6);
        chk("f2 busy drop gap", gap, 1);
        chk("f2 irq high", 32'(irq), 1);
        reg_read(ADDR_CTRL, rd);
        chk("f2 CTRL readback", rd, 32'h2);
        reg_write(ADDR_STATUS, 32'h2);
        chk("f2 irq cleared", 32'(irq), 0);

        // Too-small frame: DIM_ERR, no launch
        reg_write(ADDR_CTRL, 32'h0);
        reg_write(ADDR_DIM, (32'd2 << 16) | 32'd8);
        reg_write(ADDR_CTRL, 32'h1);
        chk("dimerr busy", 32'(busy), 0);
        chk("dimerr frame_start", 32'(frame_start), 0);
        chk("dimerr pix_ready", 32'(pix_ready), 0);
        reg_read(ADDR_STATUS, rd);
        chk("dimerr STATUS", rd, 32'h4);
        reg_write(ADDR_STATUS, 32'h4);
        reg_read(ADDR_STATUS, rd);
        chk("dimerr cleared", rd, 32'h0);

        // ABORT after 7 accepts of a 5x5 frame, with 2 results counted
        reg_write(ADDR_DIM, (32'd5 << 16) | 32'd5);
        reg_write(ADDR_CTRL, 32'h1);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            pix_valid    = 1'b1;
            dp_out_valid = (i < 2);
            @(negedge clk);
            if (line_shift) cnt++;
            tick();
        end
        pix_valid = 1'b0; dp_out_valid = 1'b0;
        chk("abort pre accepts", cnt, 7);
        reg_write(ADDR_CTRL, 32'h4);
        chk("abort busy", 32'(busy), 0);
        chk("abort pix_ready", 32'(pix_ready), 0);
        reg_read(ADDR_STATUS, rd);
        chk("abort STATUS no DONE", rd, 32'h0);
        reg_read(ADDR_RESULT, rd);
        chk("abort RESULT_CNT held", rd, 2);
        reg_write(ADDR_CTRL, 32'h1);
        chk("restart busy", 32'(busy), 1);
        chk("restart frame_start", 32'(frame_start), 1);
        reg_read(ADDR_RESULT, rd);
        chk("restart RESULT_CNT cleared", rd, 0);
        reg_write(ADDR_CTRL, 32'h4);
        chk("second abort busy", 32'(busy), 0);

        // Writes while busy are ignored; surplus results after done ignored
        reg_write(ADDR_DIM, (32'd4 << 16) | 32'd5);
        reg_write(ADDR_CTRL, 32'h1);
        reg_write(ADDR_DIM, (32'd7 << 16) | 32'd7);
        reg_write(ADDR_CTRL, 32'h1);
        chk("busy START no frame_start", 32'(frame_start), 0);
        reg_read(ADDR_DIM, rd);
        chk("busy DIM unchanged", rd, 32'h0004_0005);
        run_frame(5, 4, 1'b0, 1'b0, 200, n_acc, n_win, n_res, gap);
        chk("f3 accepts", n_acc, 20);
        chk("f3 results", n_res, 6);
        dp_out_valid = 1'b1;
        tick();
        tick();
        dp_out_valid = 1'b0;
        chk("surplus no restart", 32'(busy), 0);
        reg_read(ADDR_RESULT, rd);
        chk("surplus RESULT_CNT", rd, 6);

        // Reset during DRAIN
        reg_write(ADDR_STATUS, 32'h2);
        reg_write(ADDR_CTRL, 32'h3);
        pix_valid = 1'b1;
        repeat (20) tick();
        pix_valid = 1'b0;
        chk("drain busy", 32'(busy), 1);
        chk("drain pix_ready", 32'(pix_ready), 0);
        chk("drain state", 32'(state_dbg), 32'(ST_DRAIN));
        #1;
        reset = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst pix_ready", 32'(pix_ready), 0);
        chk("rst irq", 32'(irq), 0);
        chk("rst frame_start", 32'(frame_start), 0);
        chk("rst state", 32'(state_dbg), 32'(ST_IDLE));
        reg_read(ADDR_STATUS, rd);
        chk("rst STATUS", rd, 32'h0);
        reg_read(ADDR_DIM, rd);
        chk("rst DIM", rd, 32'h0);
        reg_read(ADDR_CTRL, rd);
        chk("rst CTRL", rd, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post-reset busy", 32'(busy), 0);

        // Final report
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
